// File: rtl/gpu_cmd_tx_if.sv
// Request handshake between the CPU core and the GPU command transmitter.
// master: CPU side (drives req_valid/req_cmd/req_param); slave: transmitter (drives req_ready).
interface gpu_cmd_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_cmd;
    logic [15:0] req_param;

    modport master (
        output req_valid,
        output req_cmd,
        output req_param,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_param,
        output req_ready
    );
endinterface

// File: rtl/gpu_cmd_tx.sv
// CPU-side transmitter: queues {cmd,param} requests and serialises them onto cpuline
// in the GPU's CMD -> PARAM -> EXEC receive loop, tracking the GPU slot phase locally.
// Ports: clk, reset (async, active-high); req (slave handshake: valid/ready/cmd/param);
//   cpuline (registered line word), busy, sent (pulse), err_nop (pulse), level (FIFO fill).
module gpu_cmd_tx #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    gpu_cmd_tx_if.slave       req,
    output logic [15:0]       cpuline,
    output logic              busy,
    output logic              sent,
    output logic              err_nop,
    output logic [LW-1:0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_CMD,
        S_PARAM,
        S_EXEC
    } slot_t;

    slot_t          slot;
    logic           live;
    logic [15:0]    cur_param;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           push;
    logic           enter_cmd;
    logic           pop;
    logic [31:0]    head;

    assign req.req_ready = (level != FULL);
    assign accept    = req.req_valid & req.req_ready;
    // NOP commands are acknowledged but never queued.
    assign push      = accept & (req.req_cmd != 16'h0000);
    // A CMD slot follows EXEC, or PARAM when the line carried no real command.
    assign enter_cmd = (slot == S_EXEC) | ((slot == S_PARAM) & ~live);
    // Uses the registered level only, so a same-edge push is never bypassed.
    assign pop       = enter_cmd & (level != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (level != '0) | live;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req.req_cmd, req.req_param};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot      <= S_CMD;
            live      <= 1'b0;
            cur_param <= '0;
            cpuline   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            sent      <= 1'b0;
            err_nop   <= 1'b0;
        end else begin
            sent    <= 1'b0;
            err_nop <= accept & (req.req_cmd == 16'h0000);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (enter_cmd) begin
                slot <= S_CMD;
                if (pop) begin
                    cpuline   <= head[31:16];
                    cur_param <= head[15:0];
                    live      <= 1'b1;
                end else begin
                    cpuline <= '0;
                    live    <= 1'b0;
                end
            end else begin
                unique case (slot)
                    S_CMD: begin
                        slot    <= S_PARAM;
                        cpuline <= live ? cur_param : 16'h0000;
                    end
                    S_PARAM: begin
                        // Only reached with live set; the idle case is enter_cmd.
                        slot    <= S_EXEC;
                        cpuline <= '0;
                        sent    <= 1'b1;
                    end
                    default: begin
                        slot    <= S_CMD;
                        cpuline <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Directed bench for gpu_cmd_tx with a small GPU receive-loop model.
// Covers idle line, single command, full FIFO cadence, NOP discard, mid-run reset, GPU writes.
module tb_gpu_cmd_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpuline;
    logic        busy;
    logic        sent;
    logic        err_nop;
    logic [2:0]  level;

    int checks = 0;
    int fails  = 0;

    gpu_cmd_tx_if bus ();

    gpu_cmd_tx #(.DEPTH(4), .LW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (bus),
        .cpuline (cpuline),
        .busy    (busy),
        .sent    (sent),
        .err_nop (err_nop),
        .level   (level)
    );

    always #5 clk = ~clk;

    // GPU receive loop: CMD slot, PARAM slot, EXEC only after a nonzero cmd.
    // Command 0x00C1 writes the param to ram[ptr] and advances ptr.
    int          g_phase;
    int          g_ptr;
    logic [15:0] g_cmd;
    logic [15:0] g_ram [0:7];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            g_phase <= 0;
            g_ptr   <= 0;
            g_cmd   <= '0;
        end else begin
            case (g_phase)
                0: begin
                    g_cmd   <= cpuline;
                    g_phase <= 1;
                end
                1: begin
                    if (g_cmd != 16'h0000) begin
                        if (g_cmd == 16'h00C1 && g_ptr < 8) begin
                            g_ram[g_ptr] <= cpuline;
                            g_ptr        <= g_ptr + 1;
                        end
                        g_phase <= 2;
                    end else begin
                        g_phase <= 0;
                    end
                end
                default: g_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] c, input logic [15:0] p);
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_param = p;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_param = '0;
    endtask

    // Leaves the bench just after the releasing negedge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] obs [25];
    logic [2:0]  lv  [25];
    logic        rd  [25];
    logic        sn  [25];

    initial begin
        int idx;
        bit rdy_q;
        int cnt_a;
        int cnt_b;
        logic [15:0] e;

        idle();

        // 1: reset state and idle line
        do_reset();
        chk("rst_line", cpuline, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_sent", sent, 1'b0);
        chk("rst_err", err_nop, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpuline != 16'h0) cnt_a++;
            if (busy || level != 3'd0 || sent) cnt_b++;
        end
        chk("idle_line_nonzero", cnt_a, 0);
        chk("idle_busy_level", cnt_b, 0);

        // 2: single command
        do_reset();
        drive(16'h00C1, 16'h1234);
        @(negedge clk);
        idle();
        chk("t2_lvl1", level, 3'd1);
        chk("t2_line1", cpuline, 16'h0);
        chk("t2_busy1", busy, 1'b1);
        @(negedge clk);
        chk("t2_cmd", cpuline, 16'h00C1);
        chk("t2_lvl2", level, 3'd0);
        @(negedge clk);
        chk("t2_param", cpuline, 16'h1234);
        chk("t2_sent3", sent, 1'b0);
        @(negedge clk);
        chk("t2_exec", cpuline, 16'h0);
        chk("t2_sent4", sent, 1'b1);
        chk("t2_busy4", busy, 1'b1);
        @(negedge clk);
        chk("t2_sent5", sent, 1'b0);
        chk("t2_busy5", busy, 1'b0);
        chk("t2_line5", cpuline, 16'h0);

        // 3: seven requests offered back to back, FIFO fills, 3-cycle cadence
        do_reset();
        idx   = 0;
        rdy_q = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            obs[k] = cpuline;
            lv[k]  = level;
            rd[k]  = bus.req_ready;
            sn[k]  = sent;
            if (bus.req_valid && rdy_q) idx++;
            rdy_q = bus.req_ready;
            if (idx < 7) drive(16'h00C0 + 16'(idx), 16'h0100 + 16'(idx));
            else idle();
        end
        chk("t3_accepted", idx, 7);
        chk("t3_lvl6", lv[6], 3'd4);
        chk("t3_rdy6", rd[6], 1'b0);
        chk("t3_rdy7", rd[7], 1'b0);
        chk("t3_lvl8", lv[8], 3'd3);
        chk("t3_rdy8", rd[8], 1'b1);
        chk("t3_lvl9", lv[9], 3'd4);
        cnt_a = 0;
        for (int k = 0; k < 25; k++) begin
            if (k >= 2 && k < 23) begin
                case ((k - 2) % 3)
                    0:       e = 16'h00C0 + 16'((k - 2) / 3);
                    1:       e = 16'h0100 + 16'((k - 2) / 3);
                    default: e = 16'h0000;
                endcase
            end else begin
                e = 16'h0000;
            end
            chk($sformatf("t3_line%0d", k), obs[k], e);
            if (sn[k]) cnt_a++;
        end
        chk("t3_sent_count", cnt_a, 7);
        chk("t3_busy_end", busy, 1'b0);

        // 4: NOP request is discarded
        do_reset();
        drive(16'h0000, 16'hBEEF);
        @(negedge clk);
        idle();
        chk("t4_err", err_nop, 1'b1);
        chk("t4_lvl", level, 3'd0);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpuline == 16'hBEEF) cnt_a++;
            if (err_nop) cnt_b++;
        end
        chk("t4_beef_seen", cnt_a, 0);
        chk("t4_err_again", cnt_b, 0);
        chk("t4_busy", busy, 1'b0);

        // 5: reset during PARAM slot with two queued
        do_reset();
        drive(16'h00C6, 16'h00FF);
        @(negedge clk);
        drive(16'h00C1, 16'h0AAA);
        @(negedge clk);
        drive(16'h00C2, 16'h0BBB);
        chk("t5_cmd", cpuline, 16'h00C6);
        @(negedge clk);
        idle();
        chk("t5_param", cpuline, 16'h00FF);
        chk("t5_lvl", level, 3'd2);
        reset = 1'b1;
        #1;
        chk("t5_async_line", cpuline, 16'h0);
        chk("t5_async_lvl", level, 3'd0);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_rdy", bus.req_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpuline != 16'h0) cnt_a++;
            if (sent || busy) cnt_b++;
        end
        chk("t5_stale_line", cnt_a, 0);
        chk("t5_stale_sent", cnt_b, 0);

        // 6: GPU model receives three writes
        do_reset();
        drive(16'h00C1, 16'h0011);
        @(negedge clk);
        drive(16'h00C1, 16'h0022);
        @(negedge clk);
        drive(16'h00C1, 16'h0033);
        @(negedge clk);
        idle();
        repeat (12) @(negedge clk);
        chk("t6_ram0", g_ram[0], 16'h0011);
        chk("t6_ram1", g_ram[1], 16'h0022);
        chk("t6_ram2", g_ram[2], 16'h0033);
        chk("t6_ptr", g_ptr, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
